// File: rtl/reaction_timer_pkg.sv
// reaction_timer_pkg: shared types and constants for the reaction-time experiment.
// Holds the FSM state encoding and the decimal digit limit used by the
// top-level controller and the chained decade counters.
package reaction_timer_pkg;

  // FSM state encoding; the values are fixed so that external debug views
  // and the bench agree on what each code means.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_TIMING = 3'd2,
    ST_DONE   = 3'd3,
    ST_CHEAT  = 3'd4
  } state_t;

  // Largest value a single BCD nibble may hold.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // True when a nibble sits at its decimal maximum.
  function automatic logic is_bcd_max(input logic [3:0] nib);
    return (nib == BCD_MAX);
  endfunction

endpackage

// File: rtl/reaction_timer_bcd_digit.sv
// reaction_timer_bcd_digit: one 4-bit decade counter (0..9) of the result chain.
// Ports: sysclk/rst_n clock and async active-low reset; i_clr synchronous clear;
//        i_en global count enable; i_cin carry from the lower digit (1 for digit 0);
//        o_digit current BCD value; o_cout carry to the next digit.
module reaction_timer_bcd_digit
  import reaction_timer_pkg::*;
(
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_cin,
  output logic [3:0] o_digit,
  output logic       o_cout
);

  logic [3:0] r_digit;
  logic       w_at_max;

  assign w_at_max = is_bcd_max(r_digit);

  // Carry is purely combinational so the whole chain advances in one edge.
  assign o_cout  = i_cin & w_at_max;
  assign o_digit = r_digit;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= 4'd0;
    end else if (i_clr) begin
      r_digit <= 4'd0;
    end else if (i_en && i_cin) begin
      // Wrap 9 -> 0; the carry-out pushes the increment into the next digit.
      r_digit <= w_at_max ? 4'd0 : (r_digit + 4'd1);
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// reaction_timer: arms the delay stage, lights the stimulus LED once the random
// delay elapses and counts 1 ms ticks in BCD until the player presses stop.
// Ports: sysclk/rst_n clock and async active-low reset; tick 1 ms count enable;
//        start/stop synchronised buttons; time_out from delay stage;
//        trig_out to delay stage; led stimulus; bcd result (digit 0 in [3:0]);
//        done result valid; cheat early press; ovf count saturated at all 9s.
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  time_out,
  output logic                  trig_out,
  output logic                  led,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done,
  output logic                  cheat,
  output logic                  ovf
);

  state_t r_state;
  logic   r_start_q;
  logic   r_trig;
  logic   r_led;
  logic   r_done;
  logic   r_cheat;
  logic   r_ovf;

  logic   w_start_rise;
  logic   w_all9;
  logic   w_clr;
  logic   w_inc;

  // ------------------------------------------------------------------
  // Start edge detect. The delay register resets to 1 so a button that
  // is already held when reset releases does not look like a fresh press.
  // ------------------------------------------------------------------
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b1;
    end else begin
      r_start_q <= start;
    end
  end

  assign w_start_rise = start & ~r_start_q;

  // ------------------------------------------------------------------
  // Counter control. Clearing happens on any accepted re-arm so a new
  // run always starts from zero; counting stops once stop is seen (stop
  // beats a coincident tick) and never runs past all 9s.
  // ------------------------------------------------------------------
  assign w_clr = w_start_rise &
                 ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_CHEAT));

  assign w_inc = (r_state == ST_TIMING) & tick & ~stop & ~w_all9;

  // ------------------------------------------------------------------
  // Decade counter chain. Each stage's carry-in is the previous stage's
  // carry-out; stage 0 always sees a carry-in, so w_inc alone advances it.
  // The final carry-out is high exactly when every digit is 9.
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic w_cin;
    logic w_cout;

    if (gi == 0) begin : g_first
      assign w_cin = 1'b1;
    end else begin : g_rest
      assign w_cin = g_digit[gi-1].w_cout;
    end

    reaction_timer_bcd_digit u_digit (
      .sysclk  (sysclk),
      .rst_n   (rst_n),
      .i_clr   (w_clr),
      .i_en    (w_inc),
      .i_cin   (w_cin),
      .o_digit (bcd[4*gi +: 4]),
      .o_cout  (w_cout)
    );
  end

  assign w_all9 = g_digit[DIGITS-1].w_cout;

  // ------------------------------------------------------------------
  // Control FSM. Outputs are written alongside the state so they reflect
  // the state being entered on the same edge.
  // ------------------------------------------------------------------
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_trig  <= 1'b0;
      r_led   <= 1'b0;
      r_done  <= 1'b0;
      r_cheat <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_rise) begin
            r_state <= ST_ARMED;
            r_trig  <= 1'b1;
            r_led   <= 1'b0;
            r_done  <= 1'b0;
            r_cheat <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end

        ST_ARMED: begin
          // An early press is judged before the delay result.
          if (stop) begin
            r_state <= ST_CHEAT;
            r_trig  <= 1'b0;
            r_cheat <= 1'b1;
          end else if (time_out) begin
            // Dropping the trigger lets the delay stage fall back to idle.
            r_state <= ST_TIMING;
            r_trig  <= 1'b0;
            r_led   <= 1'b1;
          end
        end

        ST_TIMING: begin
          if (stop) begin
            r_state <= ST_DONE;
            r_led   <= 1'b0;
            r_done  <= 1'b1;
          end else if (tick && w_all9) begin
            // Display is full; hold all 9s and flag saturation.
            r_state <= ST_DONE;
            r_led   <= 1'b0;
            r_done  <= 1'b1;
            r_ovf   <= 1'b1;
          end
        end

        ST_DONE: begin
          if (w_start_rise) begin
            r_state <= ST_ARMED;
            r_trig  <= 1'b1;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end

        ST_CHEAT: begin
          if (w_start_rise) begin
            r_state <= ST_ARMED;
            r_trig  <= 1'b1;
            r_cheat <= 1'b0;
          end
        end

        default: begin
          // Recover from an illegal encoding with all outputs quiet.
          r_state <= ST_IDLE;
          r_trig  <= 1'b0;
          r_led   <= 1'b0;
          r_done  <= 1'b0;
          r_cheat <= 1'b0;
          r_ovf   <= 1'b0;
        end
      endcase
    end
  end

  assign trig_out = r_trig;
  assign led      = r_led;
  assign done     = r_done;
  assign cheat    = r_cheat;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: directed test of the reaction timer with hand-computed
// expected values; every comparison goes through chk_eq.
module tb_reaction_timer;

  localparam int DIGITS = 4;

  logic                sysclk;
  logic                rst_n;
  logic                tick;
  logic                start;
  logic                stop;
  logic                time_out;
  logic                trig_out;
  logic                led;
  logic [4*DIGITS-1:0] bcd;
  logic                done;
  logic                cheat;
  logic                ovf;

  int n_checks;
  int n_errs;

  reaction_timer #(.DIGITS(DIGITS)) dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .tick     (tick),
    .start    (start),
    .stop     (stop),
    .time_out (time_out),
    .trig_out (trig_out),
    .led      (led),
    .bcd      (bcd),
    .done     (done),
    .cheat    (cheat),
    .ovf      (ovf)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  // n isolated tick pulses (tick high for one edge, low for the next).
  task automatic pulse_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  task automatic chk_outs(input string tag, input logic t, input logic l,
                          input logic [15:0] b, input logic d, input logic c,
                          input logic o);
    chk_eq({tag, ".trig"},  {31'd0, trig_out}, {31'd0, t});
    chk_eq({tag, ".led"},   {31'd0, led},      {31'd0, l});
    chk_eq({tag, ".bcd"},   {16'd0, bcd},      {16'd0, b});
    chk_eq({tag, ".done"},  {31'd0, done},     {31'd0, d});
    chk_eq({tag, ".cheat"}, {31'd0, cheat},    {31'd0, c});
    chk_eq({tag, ".ovf"},   {31'd0, ovf},      {31'd0, o});
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    rst_n    = 1'b0;
    tick     = 1'b0;
    start    = 1'b1;
    stop     = 1'b0;
    time_out = 1'b0;

    // --- Reset, start held through reset -------------------------------
    step(2);
    chk_outs("rst", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(3);
    chk_eq("held_start.trig", {31'd0, trig_out}, 32'd0);
    chk_eq("held_start.state", {29'd0, dut.r_state}, 32'd0);
    start = 1'b0;
    step();
    chk_eq("release.trig", {31'd0, trig_out}, 32'd0);
    start = 1'b1;
    step();
    chk_outs("arm1", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // --- Normal run: 20-cycle delay, 347 ticks, stop -------------------
    step(19);
    chk_eq("wait_delay.trig", {31'd0, trig_out}, 32'd1);
    chk_eq("wait_delay.led",  {31'd0, led},      32'd0);
    time_out = 1'b1;
    step();
    chk_eq("to_led.led",  {31'd0, led},      32'd1);
    chk_eq("to_led.trig", {31'd0, trig_out}, 32'd0);
    time_out = 1'b0;
    pulse_ticks(347);
    chk_eq("run347.bcd_pre", {16'd0, bcd}, 32'h0347);
    stop = 1'b1;
    step();
    chk_outs("run347", 1'b0, 1'b0, 16'h0347, 1'b1, 1'b0, 1'b0);
    stop = 1'b0;
    step(3);
    chk_eq("run347.hold", {16'd0, bcd}, 32'h0347);

    // --- Cheat: stop before time_out -----------------------------------
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    chk_outs("arm2", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    stop = 1'b1;
    step();
    chk_outs("cheat", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    stop = 1'b0;
    time_out = 1'b1;
    step(3);
    chk_eq("cheat.no_led", {31'd0, led}, 32'd0);
    time_out = 1'b0;
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    chk_outs("rearm", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // --- Tick and stop together at 0099 --------------------------------
    time_out = 1'b1;
    step();
    time_out = 1'b0;
    pulse_ticks(99);
    chk_eq("t99.bcd", {16'd0, bcd}, 32'h0099);
    tick = 1'b1;
    stop = 1'b1;
    step();
    tick = 1'b0;
    stop = 1'b0;
    chk_outs("tick_stop", 1'b0, 1'b0, 16'h0099, 1'b1, 1'b0, 1'b0);

    // --- Saturation at 9999 ---------------------------------------------
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    chk_outs("arm3", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    time_out = 1'b1;
    step();
    time_out = 1'b0;
    tick = 1'b1;
    step(9999);
    chk_outs("pre_ovf", 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0);
    step();
    tick = 1'b0;
    chk_outs("ovf", 1'b0, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b1);

    // --- Re-arm with time_out already high, then reset mid-run ----------
    start = 1'b0;
    step();
    start = 1'b1;
    time_out = 1'b1;
    step();
    chk_outs("arm4", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step();
    chk_eq("to_early.led",  {31'd0, led},      32'd1);
    chk_eq("to_early.trig", {31'd0, trig_out}, 32'd0);
    time_out = 1'b0;
    pulse_ticks(123);
    chk_eq("t123.bcd", {16'd0, bcd}, 32'h0123);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step(2);
    chk_eq("post_rst.state", {29'd0, dut.r_state}, 32'd0);
    chk_outs("post_rst", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    chk_eq("post_rst.arm", {31'd0, trig_out}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
Downstream consumer of the programmable delay stage in the reaction-time experiment. It arms the delay stage through `trig_out` and waits for `time_out`. It then lights the stimulus LED and counts `tick` pulses (1 ms from the tick generator) in BCD until the player presses `stop`. The BCD result drives the 7-segment display path; an early press is flagged as a cheat.

Parameters:
DIGITS, 4, number of BCD digits in the result counter (one 4-bit nibble per digit)

Ports:
sysclk   in   1           system clock, all logic on rising edge
rst_n    in   1           asynchronous, active-low reset
tick     in   1           one-sysclk-wide count enable (1 ms period)
start    in   1           synchronised push-button level; a rising edge arms a run
stop     in   1           synchronised push-button level; high = player response
time_out in   1           from delay stage; high when the random delay has elapsed
trig_out out  1           to delay-stage trigger input
led      out  1           stimulus LED, on while timing
bcd      out  4*DIGITS    result; digit 0 in bits [3:0], least significant
done     out  1           valid result held on bcd
cheat    out  1           stop pressed before time_out
ovf      out  1           count saturated at all-9s

Behaviour:
- Reset is asynchronous and active-low. It is the only reset; all other behaviour is synchronous to sysclk.
- Reset values:
  - State = IDLE.
  - bcd = 0, and trig_out, led, done, cheat and ovf are all 0.
  - The start edge-detect register is reset to 1, so a button held through reset does not arm a run.
- Start edge: start_rise = start & ~start_q, where start_q is start delayed by one sysclk.
- States: IDLE, ARMED, TIMING, DONE, CHEAT.
- IDLE:
  - On start_rise, go to ARMED.
  - In the same cycle, clear bcd and ovf.
- ARMED:
  - trig_out = 1 (registered, visible the cycle after entry).
  - Priority is stop over time_out:
    - stop = 1: go to CHEAT.
    - Otherwise, time_out = 1: go to TIMING.
- TIMING:
  - led = 1 and trig_out = 0. Dropping trig_out lets the delay stage return to its idle state.
  - Each cycle with tick = 1 and stop = 0 increments bcd by one in decimal. Digit i carries when it is 9 and all lower digits are 9; carried digits wrap to 0.
  - stop = 1: go to DONE. A tick in the same cycle is not counted (stop wins).
  - tick = 1 while bcd is all 9s: bcd holds, ovf = 1, go to DONE.
  - start_rise in this state is ignored.
- DONE:
  - done = 1, led = 0, bcd held.
  - On start_rise: go to ARMED, clear bcd, clear done and ovf.
- CHEAT:
  - cheat = 1, bcd held at 0.
  - On start_rise: go to ARMED and clear cheat.
- Output timing:
  - All outputs are registered and decoded from the next state, so they change in the same edge as the state change.
  - Latency from time_out high to led high is 1 sysclk.
  - Latency from stop high to done high is 1 sysclk.
- Boundary conditions:
  - stop held high across start_rise: ARMED is entered, and the next cycle goes to CHEAT.
  - time_out already high on entry to ARMED: TIMING is entered on the next edge.
  - Reset mid-run: everything returns to the reset values immediately. No partial result is retained.
  - Undefined state encodings return to IDLE.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE = 3'd0, ARMED = 3'd1, TIMING = 3'd2, DONE = 3'd3, CHEAT = 3'd4).
  - BCD_MAX = 4'd9.
- One sub-module, bcd_digit: a 4-bit decade counter with clear, enable, carry-in and carry-out (carry-out = carry-in & digit == 9).
  - DIGITS instances are chained through a generate loop.
  - The top level holds the FSM and the start edge detect.

Test Plan:
- Reset with start = 1, then start held → stays IDLE, trig_out = 0; a start rise after a release → ARMED, trig_out = 1 one cycle later.
- Arm, time_out after 20 cycles, 347 ticks, then stop → led high 1 cycle after time_out, bcd = 16'h0347, done = 1, led = 0.
- Arm, stop high while time_out = 0 → cheat = 1, bcd = 0, led never asserted. A start rise re-arms and clears cheat.
- In TIMING, tick and stop in the same cycle at bcd = 16'h0099 → bcd stays 0099, done = 1.
- Preload via 9999 ticks (DIGITS = 4), then one more tick → bcd = 16'h9999, ovf = 1, done = 1.
- rst_n low mid-TIMING at bcd = 16'h0123 → all outputs 0 asynchronously; after release, state is IDLE.
